// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiply controller.
// MUL_LATENCY is the MulStall length in cycles, used by hazard logic and the bench.
package mul_pkg;

    localparam int unsigned MUL_WIDTH   = 32;
    localparam int unsigned MUL_CNT_W   = 6;
    localparam int unsigned MUL_LATENCY = MUL_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mulState;

endpackage

// File: rtl/mul_shift_add_step.sv
// One radix-2 iteration: conditionally add the multiplicand into the upper half,
// then shift {carry, acc, multiplier} right by one.
module mul_shift_add_step #(
    parameter int unsigned WIDTH = mul_pkg::MUL_WIDTH
) (
    input  logic [WIDTH-1:0]   mcand,
    input  logic [2*WIDTH-1:0] prodIn,
    output logic [2*WIDTH-1:0] prodOut
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, prodIn[2*WIDTH-1:WIDTH]};
        if (prodIn[0]) begin
            sum = sum + {1'b0, mcand};
        end
        prodOut = {sum, prodIn[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add multiply controller for EX; stalls the pipe for WIDTH+1 cycles.
// Define MUL_SIGNED_EN to honour Signed_ex (magnitude conversion plus final negate).
module mul_seq_ctrl #(
    parameter int unsigned WIDTH = mul_pkg::MUL_WIDTH,
    parameter int unsigned CNT_W = mul_pkg::MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MUL_ex,
    input  logic             Signed_ex,
    input  logic [WIDTH-1:0] RsData_ex,
    input  logic [WIDTH-1:0] RtData_ex,
    input  logic             Flush,
    output logic             MulStall,
    output logic             MulDone,
    output logic             Busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    import mul_pkg::*;

    mulState            state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodNext;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   rsMag;
    logic [WIDTH-1:0]   rtMag;
    logic               start;

    assign start = (state == IDLE) && MUL_ex && !Flush;

`ifdef MUL_SIGNED_EN
    logic sign;

    always_comb begin
        rsMag  = (Signed_ex && RsData_ex[WIDTH-1]) ? -RsData_ex : RsData_ex;
        rtMag  = (Signed_ex && RtData_ex[WIDTH-1]) ? -RtData_ex : RtData_ex;
        result = sign ? -prodNext : prodNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
        end else if (start) begin
            sign <= Signed_ex & (RsData_ex[WIDTH-1] ^ RtData_ex[WIDTH-1]);
        end
    end
`else
    logic unusedSigned;

    assign unusedSigned = Signed_ex;
    assign rsMag        = RsData_ex;
    assign rtMag        = RtData_ex;
    assign result       = prodNext;
`endif

    mul_shift_add_step #(
        .WIDTH(WIDTH)
    ) uStep (
        .mcand  (mcand),
        .prodIn (prod),
        .prodOut(prodNext)
    );

    // Gated by rst_n so a held MUL_ex cannot stall the pipe while in reset.
    assign MulStall = rst_n && (start || (state == RUN));
    assign Busy     = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            prod    <= '0;
            Hi      <= '0;
            Lo      <= '0;
            MulDone <= 1'b0;
        end else begin
            MulDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= rsMag;
                        prod  <= {{WIDTH{1'b0}}, rtMag};
                        cnt   <= CNT_W'(WIDTH);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else begin
                        prod <= prodNext;
                        cnt  <= cnt - CNT_W'(1);
                        // Last iteration: product lands in Hi/Lo as DONE is entered.
                        if (cnt == CNT_W'(1)) begin
                            state   <= DONE;
                            Hi      <= result[2*WIDTH-1:WIDTH];
                            Lo      <= result[WIDTH-1:0];
                            MulDone <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboarded bench for mul_seq_ctrl: directed multiplies, flush, back-to-back and reset.
`timescale 1ns/1ps
module tb_mul_seq_ctrl;

    import mul_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         MUL_ex = 1'b0;
    logic         Signed_ex = 1'b0;
    logic         Flush = 1'b0;
    logic [W-1:0] RsData_ex = '0;
    logic [W-1:0] RtData_ex = '0;
    logic         MulStall;
    logic         MulDone;
    logic         Busy;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } expT;

    expT expQ[$];
    expT monE;
    int  cyc = 0;
    int  total = 0;
    int  passed = 0;

    mul_seq_ctrl #(
        .WIDTH(W),
        .CNT_W(MUL_CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MUL_ex   (MUL_ex),
        .Signed_ex(Signed_ex),
        .RsData_ex(RsData_ex),
        .RtData_ex(RtData_ex),
        .Flush    (Flush),
        .MulStall (MulStall),
        .MulDone  (MulDone),
        .Busy     (Busy),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every MulDone pulse must match the oldest expected product and cycle.
    always @(negedge clk) begin
        if (MulDone === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpectedDone", {63'b0, MulDone}, 64'd0);
            end else begin
                monE = expQ.pop_front();
                check("product", {Hi, Lo}, monE.prod);
                check("doneCycle", 64'(cyc), 64'(monE.cyc));
            end
        end
    end

    // Issue one multiply (MUL_ex held until done), count stall cycles, scramble operands mid-run.
    task automatic runMul(input logic [W-1:0] rs, input logic [W-1:0] rt, input logic sgn,
                          input logic [2*W-1:0] prodExp);
        int  stalls = 0;
        int  budget = 0;
        expT e;
        RsData_ex = rs;
        RtData_ex = rt;
        Signed_ex = sgn;
        MUL_ex    = 1'b1;
        e.prod    = prodExp;
        e.cyc     = cyc + MUL_LATENCY;
        expQ.push_back(e);
        forever begin
            @(negedge clk);
            if (MulDone === 1'b1 || budget > 3 * MUL_LATENCY) break;
            if (MulStall === 1'b1) stalls++;
            if (budget == 2) begin
                RsData_ex = ~rs;
                RtData_ex = ~rt;
                Signed_ex = ~sgn;
            end
            budget++;
        end
        check("stallCycles", 64'(stalls), 64'(MUL_LATENCY));
        check("stallInDone", {63'b0, MulStall}, 64'd0);
        tick();
        MUL_ex = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #1;
        check("rstHi", 64'(Hi), 64'd0);
        check("rstLo", 64'(Lo), 64'd0);
        check("rstDone", {63'b0, MulDone}, 64'd0);
        check("rstBusy", {63'b0, Busy}, 64'd0);
        check("rstStall", {63'b0, MulStall}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        runMul(32'd7, 32'd6, 1'b0, 64'd42);
`ifdef MUL_SIGNED_EN
        runMul(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        runMul(32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
`else
        runMul(32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1);
`endif
        runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);

        // Flush together with MUL_ex in IDLE must not start.
        tick();
        RsData_ex = 32'd7;
        RtData_ex = 32'd6;
        MUL_ex    = 1'b1;
        Flush     = 1'b1;
        @(negedge clk);
        check("idleFlushStall", {63'b0, MulStall}, 64'd0);
        tick();
        MUL_ex = 1'b0;
        Flush  = 1'b0;
        @(negedge clk);
        check("idleFlushBusy", {63'b0, Busy}, 64'd0);

        // Flush at cycle 10 of a run.
        tick();
        Signed_ex = 1'b0;
        MUL_ex    = 1'b1;
        repeat (10) tick();
        Flush = 1'b1;
        @(negedge clk);
        check("stallFlushCycle", {63'b0, MulStall}, 64'd1);
        tick();
        Flush  = 1'b0;
        MUL_ex = 1'b0;
        @(negedge clk);
        check("stallAfterFlush", {63'b0, MulStall}, 64'd0);
        check("busyAfterFlush", {63'b0, Busy}, 64'd0);
        check("hiloAfterFlush", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        tick();
        runMul(32'd5, 32'd9, 1'b0, 64'd45);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        runMul(32'd3, 32'd4, 1'b0, 64'd12);
        runMul(32'd0, 32'h1234_5678, 1'b0, 64'd0);

        // Reset during cycle 15 of a run.
        runMul(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        tick();
        RsData_ex = 32'd9;
        RtData_ex = 32'd9;
        MUL_ex    = 1'b1;
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        check("midRstHi", 64'(Hi), 64'd0);
        check("midRstLo", 64'(Lo), 64'd0);
        check("midRstBusy", {63'b0, Busy}, 64'd0);
        check("midRstStall", {63'b0, MulStall}, 64'd0);
        check("midRstDone", {63'b0, MulDone}, 64'd0);
        tick();
        rst_n  = 1'b1;
        MUL_ex = 1'b0;
        tick();
        runMul(32'd2, 32'd2, 1'b0, 64'd4);

        repeat (3) tick();
        check("pendingDone", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative multi-cycle multiply controller for the EX stage. It is triggered by the decoded MUL control once it reaches EX.
- Sequences a radix-2 shift-add datapath over WIDTH cycles.
- Holds the pipeline with MulStall until the product is ready, then pulses MulDone and presents Hi/Lo for writeback.
- Sits beside the ALU and feeds the same stall network as the load-use hazard detector.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits, split into Hi and Lo.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MUL_ex  input  1  multiply instruction present in EX.
- Signed_ex  input  1  1 = signed multiply (mult), 0 = unsigned (multu).
- RsData_ex  input  WIDTH  multiplicand (forwarded value).
- RtData_ex  input  WIDTH  multiplier (forwarded value).
- Flush  input  1  abort the operation in progress (branch/jump squash of EX).
- MulStall  output  1  freeze PC, IF/ID and ID/EX.
- MulDone  output  1  one-cycle pulse: Hi/Lo updated this cycle.
- Busy  output  1  sequencer in RUN.
- Hi  output  WIDTH  upper product word.
- Lo  output  WIDTH  lower product word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, accumulator=0, Hi=0, Lo=0, MulDone=0, Busy=0. MulStall=0 while in reset.
- States:
  - IDLE: start when MUL_ex=1 and Flush=0. Latch |Rs| and |Rt| (magnitude if Signed_ex, else raw), latch sign = Rs[W-1]^Rt[W-1] & Signed_ex, clear accumulator, counter=WIDTH. Go to RUN.
  - RUN: each cycle, if multiplier LSB=1, add multiplicand to the accumulator upper half (WIDTH+1-bit add, carry kept). Shift the {carry, acc, multiplier} concatenation right by 1 and decrement the counter. When counter reaches 1 on this edge, go to DONE.
  - DONE: Hi/Lo registered from the accumulator (two's-complement negate of the 2W result if sign=1). MulDone=1 for exactly this cycle. Next state IDLE unconditionally. MUL_ex in DONE is the completing instruction and is ignored.
- MulStall = (IDLE & MUL_ex & ~Flush) | RUN. It is combinational, so the start cycle already stalls. It is 0 in DONE, so the instruction advances.
- Latency is fixed and independent of operand values:
  - Start cycle = 0; RUN occupies cycles 1..WIDTH; DONE at cycle WIDTH+1.
  - MulStall is high for cycles 0..WIDTH, i.e. WIDTH+1 cycles.
- Busy = (state==RUN).
- Flush in RUN: return to IDLE next edge. No MulDone; Hi/Lo unchanged; MulStall drops that edge.
- Flush in IDLE together with MUL_ex: no start.
- Flush in DONE: Hi/Lo still update (the instruction committed).
- Hi/Lo hold their last values between operations.
- Back-to-back MULs: the second is accepted in the IDLE cycle after DONE, one dead cycle minimum.
- Operands are sampled only in the start cycle; later changes on RsData_ex/RtData_ex are ignored.
- Reset mid-RUN: immediate IDLE, Hi/Lo cleared.

Optional Feature:
- Macro MUL_SIGNED_EN.
- Defined: Signed_ex honoured (magnitude conversion plus final negate).
- Undefined: Signed_ex ignored, all multiplies unsigned; the negate logic and sign flop are not built.

Decomposition:
- Shared package mul_pkg:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH/CNT_W constants;
  - the MUL_LATENCY = WIDTH+1 constant used by the hazard logic and the bench.
- Sub-module mul_shift_add_step: the combinational one-iteration datapath (conditional add plus right shift, WIDTH-generic).
- The FSM, counter and Hi/Lo registers stay in mul_seq_ctrl.

Test Plan:
- Unsigned, Rs=7, Rt=6, MUL_ex pulse held until done → MulStall high cycles 0..32; MulDone at cycle 33; Hi=0x00000000, Lo=0x0000002A.
- Unsigned, 0xFFFFFFFF × 0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
- MUL_SIGNED_EN defined, signed, Rs=0xFFFFFFFD (−3), Rt=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; same operands with MUL_SIGNED_EN undefined → Hi=0x00000004, Lo=0xFFFFFFF1.
- Start 7×6, assert Flush at cycle 10 → MulStall low from cycle 11, no MulDone, Hi/Lo keep previous values; a new MUL at cycle 12 completes normally at cycle 45.
- Back-to-back: 3×4 then 0×0x12345678 → first MulDone Lo=12; second accepted in the following IDLE cycle; second MulDone exactly 33 cycles after the second start with Hi=Lo=0.
- rst_n low at cycle 15 of a run → outputs zero immediately (async), state IDLE; after release a 2×2 multiply yields Lo=4 on schedule.
